// File: rtl/bank_sched_stats_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bank_sched_stats_pkg                                                   |
// | Shared entry layout and saturating arithmetic for the latency tracker. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package bank_sched_stats_pkg;

   localparam int LAT_W = 32;
   localparam int SUM_W = 48;

   typedef struct packed {
      logic        valid;
      logic [31:0] id;
      logic [31:0] addr;
      logic        rd;
      logic        wr;
      logic [63:0] issue_cycle;
   } entry_t;

   function automatic logic [LAT_W-1:0] sat_latency(input logic [63:0] diff);
      return (|diff[63:LAT_W]) ? {LAT_W{1'b1}} : diff[LAT_W-1:0];
   endfunction

   function automatic logic [SUM_W-1:0] sat_add_sum(input logic [SUM_W-1:0] a,
                                                    input logic [LAT_W-1:0] b);
      logic [SUM_W:0] s;
      s = {1'b0, a} + {{(SUM_W-LAT_W+1){1'b0}}, b};
      return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] a);
      return (&a) ? a : a + 32'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] a);
      return (&a) ? a : a + 16'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bank_sched_outstanding_table.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bank_sched_outstanding_table                                           |
// | Outstanding-request table: lowest-free allocation, lowest-match CAM.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module bank_sched_outstanding_table
   import bank_sched_stats_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            alloc_req,
   input  entry_t          alloc_entry,
   input  logic            lookup_req,
   input  logic [31:0]     lookup_id,
   output logic            drop,
   output logic            hit,
   output entry_t          hit_entry,
   output logic [IDX_W:0]  count,
   output logic            full
);

   entry_t           r_entries [DEPTH];
   logic             w_free_any;
   logic [IDX_W-1:0] w_free_idx;
   logic             w_match;
   logic [IDX_W-1:0] w_hit_idx;
   logic [IDX_W:0]   w_count;

   // Scan high-to-low so the lowest index is the last (winning) assignment;
   // everything here sees the table as it stood before this cycle's writes.
   always_comb begin
      w_free_any = 1'b0;
      w_free_idx = '0;
      w_match    = 1'b0;
      w_hit_idx  = '0;
      w_count    = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!r_entries[i].valid) begin
            w_free_any = 1'b1;
            w_free_idx = IDX_W'(i);
         end
         if (r_entries[i].valid && (r_entries[i].id == lookup_id)) begin
            w_match   = 1'b1;
            w_hit_idx = IDX_W'(i);
         end
         w_count = w_count + {{IDX_W{1'b0}}, r_entries[i].valid};
      end
   end

   assign hit       = lookup_req & w_match;
   assign hit_entry = r_entries[w_hit_idx];
   assign drop      = alloc_req & ~w_free_any;
   assign count     = w_count;
   assign full      = (w_count == (IDX_W+1)'(DEPTH));

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_entries[i].valid <= 1'b0;
         end
      end else begin
         if (alloc_req && w_free_any) begin
            r_entries[w_free_idx] <= alloc_entry;
         end
         if (hit) begin
            r_entries[w_hit_idx].valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/bank_scheduler_response_latency_tracker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bank_scheduler_response_latency_tracker                                |
// | Per-bank request latency statistics; CSV log via                       |
// | BANK_SCHED_RESP_CSV_LOG_EN.                                            |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module bank_scheduler_response_latency_tracker
   import bank_sched_stats_pkg::*;
#(
   parameter int RANK      = 0,
   parameter int BANKGROUP = 0,
   parameter int BANK      = 0,
   parameter int DEPTH     = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_fire,
   input  logic                    rd_en,
   input  logic                    wr_en,
   input  logic [31:0]             addr,
   input  logic [31:0]             request_id,
   input  logic                    resp_fire,
   input  logic [31:0]             resp_id,
   input  logic [63:0]             globalCycle,
   output logic [$clog2(DEPTH):0]  outstanding,
   output logic                    table_full,
   output logic [31:0]             rd_done,
   output logic [31:0]             wr_done,
   output logic [SUM_W-1:0]        lat_sum,
   output logic [LAT_W-1:0]        lat_min,
   output logic [LAT_W-1:0]        lat_max,
   output logic [15:0]             drop_cnt,
   output logic [15:0]             orphan_cnt
);

   if ((DEPTH < 2) || (DEPTH > 64) || ((DEPTH & (DEPTH - 1)) != 0) ||
       (RANK < 0) || (BANKGROUP < 0) || (BANK < 0)) begin : g_bad_params
      $error("bank_scheduler_response_latency_tracker: illegal parameters");
   end

   entry_t             w_alloc_entry;
   entry_t             w_hit_entry;
   logic               w_hit;
   logic               w_drop;
   logic [LAT_W-1:0]   w_latency;

   logic [31:0]        r_rd_done;
   logic [31:0]        r_wr_done;
   logic [SUM_W-1:0]   r_lat_sum;
   logic [LAT_W-1:0]   r_lat_min;
   logic [LAT_W-1:0]   r_lat_max;
   logic [15:0]        r_drop_cnt;
   logic [15:0]        r_orphan_cnt;

   assign w_alloc_entry = '{valid: 1'b1, id: request_id, addr: addr, rd: rd_en,
                            wr: wr_en, issue_cycle: globalCycle};

   bank_sched_outstanding_table #(
      .DEPTH (DEPTH)
   ) u_table (
      .clk         (clk),
      .reset       (reset),
      .alloc_req   (req_fire),
      .alloc_entry (w_alloc_entry),
      .lookup_req  (resp_fire),
      .lookup_id   (resp_id),
      .drop        (w_drop),
      .hit         (w_hit),
      .hit_entry   (w_hit_entry),
      .count       (outstanding),
      .full        (table_full)
   );

   assign w_latency = sat_latency(globalCycle - w_hit_entry.issue_cycle);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_done    <= '0;
         r_wr_done    <= '0;
         r_lat_sum    <= '0;
         r_lat_min    <= '1;
         r_lat_max    <= '0;
         r_drop_cnt   <= '0;
         r_orphan_cnt <= '0;
      end else begin
         if (w_hit) begin
            r_lat_sum <= sat_add_sum(r_lat_sum, w_latency);
            if (w_latency < r_lat_min) r_lat_min <= w_latency;
            if (w_latency > r_lat_max) r_lat_max <= w_latency;
            if (w_hit_entry.rd) r_rd_done <= sat_inc32(r_rd_done);
            if (w_hit_entry.wr) r_wr_done <= sat_inc32(r_wr_done);
         end else if (resp_fire) begin
            r_orphan_cnt <= sat_inc16(r_orphan_cnt);
         end
         if (w_drop) begin
            r_drop_cnt <= sat_inc16(r_drop_cnt);
         end
      end
   end

   assign rd_done    = r_rd_done;
   assign wr_done    = r_wr_done;
   assign lat_sum    = r_lat_sum;
   assign lat_min    = r_lat_min;
   assign lat_max    = r_lat_max;
   assign drop_cnt   = r_drop_cnt;
   assign orphan_cnt = r_orphan_cnt;

`ifdef BANK_SCHED_RESP_CSV_LOG_EN
   initial begin
      $display("output_request_stats_scheduler_rank%0d_bg%0d_bank%0d.csv",
               RANK, BANKGROUP, BANK);
      $display("RequestID,Address,Read,Write,IssueCycle,CompleteCycle,Latency");
   end

   // Rows follow the same edge that commits the statistics.
   always @(posedge clk) begin
      if (!reset) begin
         if (w_hit)
            $display("%0d,0x%08h,%0d,%0d,%0d,%0d,%0d", w_hit_entry.id,
                     w_hit_entry.addr, w_hit_entry.rd, w_hit_entry.wr,
                     w_hit_entry.issue_cycle, globalCycle, w_latency);
         if (w_drop)
            $display("DROP,%0d,%0d", request_id, globalCycle);
         if (resp_fire && !w_hit)
            $display("ORPHAN,%0d,%0d", resp_id, globalCycle);
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bank_scheduler_response_latency_tracker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_bank_scheduler_response_latency_tracker                             |
// | Directed scenarios plus random traffic against a behavioural model.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_bank_scheduler_response_latency_tracker;

   localparam int DEPTH = 16;
   localparam logic [63:0] ONES32 = 64'hFFFF_FFFF;
   localparam logic [63:0] ONES48 = 64'hFFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_fire, rd_en, wr_en, resp_fire;
   logic [31:0] addr, request_id, resp_id;
   logic [63:0] globalCycle;
   logic [4:0]  outstanding;
   logic        table_full;
   logic [31:0] rd_done, wr_done, lat_min, lat_max;
   logic [47:0] lat_sum;
   logic [15:0] drop_cnt, orphan_cnt;

   int checks   = 0;
   int failures = 0;

   // Model: a slot list plus plain statistic variables.
   bit          m_valid [DEPTH];
   logic [31:0] m_id    [DEPTH];
   bit          m_rd    [DEPTH];
   bit          m_wr    [DEPTH];
   logic [63:0] m_issue [DEPTH];
   logic [63:0] m_rd_done, m_wr_done, m_sum, m_min, m_max, m_drop, m_orphan;

   bank_scheduler_response_latency_tracker #(
      .RANK(0), .BANKGROUP(0), .BANK(0), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .req_fire(req_fire), .rd_en(rd_en), .wr_en(wr_en),
      .addr(addr), .request_id(request_id), .resp_fire(resp_fire), .resp_id(resp_id),
      .globalCycle(globalCycle), .outstanding(outstanding), .table_full(table_full),
      .rd_done(rd_done), .wr_done(wr_done), .lat_sum(lat_sum), .lat_min(lat_min),
      .lat_max(lat_max), .drop_cnt(drop_cnt), .orphan_cnt(orphan_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, globalCycle);
      end
   endtask

   task automatic model_step();
      int hit_slot  = -1;
      int free_slot = -1;
      logic [63:0] lat;
      if (reset) begin
         foreach (m_valid[i]) m_valid[i] = 0;
         m_rd_done = 0; m_wr_done = 0; m_sum = 0; m_min = ONES32; m_max = 0;
         m_drop = 0; m_orphan = 0;
         return;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (hit_slot < 0 && m_valid[i] && m_id[i] == resp_id) hit_slot = i;
         if (free_slot < 0 && !m_valid[i]) free_slot = i;
      end
      if (resp_fire) begin
         if (hit_slot >= 0) begin
            lat = globalCycle - m_issue[hit_slot];
            if (lat > ONES32) lat = ONES32;
            m_sum = (m_sum + lat > ONES48) ? ONES48 : m_sum + lat;
            if (lat < m_min) m_min = lat;
            if (lat > m_max) m_max = lat;
            if (m_rd[hit_slot] && m_rd_done != ONES32) m_rd_done++;
            if (m_wr[hit_slot] && m_wr_done != ONES32) m_wr_done++;
         end else if (m_orphan != 64'hFFFF) begin
            m_orphan++;
         end
      end
      if (req_fire) begin
         if (free_slot >= 0) begin
            m_valid[free_slot] = 1; m_id[free_slot] = request_id;
            m_rd[free_slot] = rd_en; m_wr[free_slot] = wr_en;
            m_issue[free_slot] = globalCycle;
         end else if (m_drop != 64'hFFFF) begin
            m_drop++;
         end
      end
      if (resp_fire && hit_slot >= 0) m_valid[hit_slot] = 0;
   endtask

   task automatic compare_all();
      int cnt = 0;
      foreach (m_valid[i]) cnt += int'(m_valid[i]);
      chk("outstanding", 64'(outstanding), 64'(cnt));
      chk("table_full",  64'(table_full),  64'(cnt == DEPTH));
      chk("rd_done",     64'(rd_done),     m_rd_done);
      chk("wr_done",     64'(wr_done),     m_wr_done);
      chk("lat_sum",     64'(lat_sum),     m_sum);
      chk("lat_min",     64'(lat_min),     m_min);
      chk("lat_max",     64'(lat_max),     m_max);
      chk("drop_cnt",    64'(drop_cnt),    m_drop);
      chk("orphan_cnt",  64'(orphan_cnt),  m_orphan);
   endtask

   // One clock: drive, let the edge happen, advance the model, compare #1 later.
   task automatic step(input bit rq, input bit rd, input bit wr, input logic [31:0] id,
                       input bit rs, input logic [31:0] rid);
      req_fire = rq; rd_en = rd; wr_en = wr; request_id = id;
      addr = 32'h1000_0000 | (id << 4);
      resp_fire = rs; resp_id = rid;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      globalCycle = globalCycle + 64'd1;
   endtask

   task automatic idle_until(input logic [63:0] cyc);
      while (globalCycle < cyc) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(0, 0, 0, 0, 0, 0);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; req_fire = 0; rd_en = 0; wr_en = 0; resp_fire = 0;
      addr = 0; request_id = 0; resp_id = 0; globalCycle = 64'd0;
      do_reset();
      chk("reset_lat_min", 64'(lat_min), ONES32);
      chk("reset_outstanding", 64'(outstanding), 64'd0);

      // Single read: issue at 100, retire at 130.
      globalCycle = 64'd100;
      step(1, 1, 0, 5, 0, 0);
      idle_until(64'd130);
      step(0, 0, 0, 0, 1, 5);
      chk("single_rd_done", 64'(rd_done), 64'd1);
      chk("single_lat_sum", 64'(lat_sum), 64'd30);
      chk("single_lat_min", 64'(lat_min), 64'd30);
      chk("single_lat_max", 64'(lat_max), 64'd30);
      chk("single_outstanding", 64'(outstanding), 64'd0);

      // Fill the table, then overflow it.
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1, i[0], ~i[0], i, 0, 0);
      chk("fill_full", 64'(table_full), 64'd1);
      step(1, 1, 0, 99, 0, 0);
      chk("fill_drop1", 64'(drop_cnt), 64'd1);
      step(1, 1, 0, 99, 1, 3);
      chk("fill_drop2", 64'(drop_cnt), 64'd2);
      chk("fill_outstanding15", 64'(outstanding), 64'd15);

      // Orphan on empty table, then same-cycle request/response.
      do_reset();
      step(0, 0, 0, 0, 1, 42);
      chk("orphan_empty", 64'(orphan_cnt), 64'd1);
      step(1, 1, 0, 7, 1, 7);
      chk("orphan_same_cycle", 64'(orphan_cnt), 64'd2);
      chk("orphan_outstanding", 64'(outstanding), 64'd1);
      step(0, 0, 0, 0, 1, 7);
      chk("next_cycle_latency", 64'(lat_max), 64'd1);

      // Duplicate IDs retire in slot order.
      do_reset();
      globalCycle = 64'd10;
      step(1, 1, 0, 9, 0, 0);
      idle_until(64'd20);
      step(1, 0, 1, 9, 0, 0);
      idle_until(64'd50);
      step(0, 0, 0, 0, 1, 9);
      chk("dup_first_sum", 64'(lat_sum), 64'd40);
      chk("dup_first_rd", 64'(rd_done), 64'd1);
      idle_until(64'd60);
      step(0, 0, 0, 0, 1, 9);
      chk("dup_sum", 64'(lat_sum), 64'd80);
      chk("dup_wr", 64'(wr_done), 64'd1);

      // Latency saturation across a 2^33 jump.
      do_reset();
      globalCycle = 64'd1000;
      step(1, 0, 1, 1, 0, 0);
      globalCycle = 64'd1000 + (64'd1 << 33);
      step(0, 0, 0, 0, 1, 1);
      chk("sat_lat_max", 64'(lat_max), ONES32);
      chk("sat_lat_sum", 64'(lat_sum), ONES32);

      // Reset mid-flight discards entries.
      do_reset();
      step(1, 1, 0, 1, 0, 0);
      step(1, 1, 0, 2, 0, 0);
      step(1, 0, 1, 3, 0, 0);
      chk("mid_outstanding3", 64'(outstanding), 64'd3);
      do_reset();
      chk("mid_reset_out", 64'(outstanding), 64'd0);
      chk("mid_reset_min", 64'(lat_min), ONES32);
      step(0, 0, 0, 0, 1, 2);
      chk("mid_old_orphan", 64'(orphan_cnt), 64'd1);

      // Random traffic: a request-heavy phase to reach full/drop, then balanced.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         int resp_pct;
         resp_pct = (n < 1000) ? 20 : 55;
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            if ($urandom_range(0, 99) == 0) globalCycle = globalCycle + 64'($urandom_range(0, 5000));
            if ($urandom_range(0, 499) == 0) globalCycle = globalCycle + (64'd1 << 32);
            step($urandom_range(0, 99) < 60, 1'($urandom), 1'($urandom), $urandom_range(0, 7),
                 $urandom_range(0, 99) < resp_pct, $urandom_range(0, 8));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
